// File: rtl/test_circuit_sync.sv
// test_circuit_sync: registered full adder {e,d} = a+b+c with PIPE_STAGES latency and a matching valid pipe
module test_circuit_sync #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] d,
  output logic             e,
  output logic             out_valid
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] r_sum [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_vld;
  assign w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) r_sum[i] <= '0;
      r_vld <= '0;
    end else begin
      r_sum[0] <= w_sum;
      r_vld[0] <= in_valid;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_sum[i] <= r_sum[i-1];
        r_vld[i] <= r_vld[i-1];
      end
    end
  end
  assign d         = r_sum[PIPE_STAGES-1][WIDTH-1:0];
  assign e         = r_sum[PIPE_STAGES-1][WIDTH];
  assign out_valid = r_vld[PIPE_STAGES-1];
endmodule

// File: tb/tb_test_circuit_sync.sv
// tb_test_circuit_sync: directed checks of the registered full adder across width/latency variants
module tb_test_circuit_sync;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c = 1'b0, in_valid = 1'b0;
  logic       d1, e1, ov1, d3, e3, ov3, e8, ov8, e83, ov83;
  logic [7:0] d8, d83;
  int         n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  test_circuit_sync #(.WIDTH(1), .PIPE_STAGES(1)) dut1 (.clk(clk), .rst(rst), .a(a8[0]), .b(b8[0]), .c(c),
    .in_valid(in_valid), .d(d1), .e(e1), .out_valid(ov1));
  test_circuit_sync #(.WIDTH(1), .PIPE_STAGES(3)) dut3 (.clk(clk), .rst(rst), .a(a8[0]), .b(b8[0]), .c(c),
    .in_valid(in_valid), .d(d3), .e(e3), .out_valid(ov3));
  test_circuit_sync #(.WIDTH(8), .PIPE_STAGES(1)) dut8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .c(c),
    .in_valid(in_valid), .d(d8), .e(e8), .out_valid(ov8));
  test_circuit_sync #(.WIDTH(8), .PIPE_STAGES(3)) dut83 (.clk(clk), .rst(rst), .a(a8), .b(b8), .c(c),
    .in_valid(in_valid), .d(d83), .e(e83), .out_valid(ov83));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    in_valid = 1'b0;
    repeat (4) step();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c = 1'($urandom); in_valid = 1'b1;
      step();
      n_total++;
      if ({ov1, e1, d1, ov3, e3, d3, ov8, e8, d8, ov83, e83, d83} !== '0)
        $display("FAIL reset cyc%0d: got ov1e1d1=%b%b%b ov3e3d3=%b%b%b ov8=%b e8=%b d8=%h ov83=%b e83=%b d83=%h, want all 0",
          k, ov1, e1, d1, ov3, e3, d3, ov8, e8, d8, ov83, e83, d83);
      else n_pass++;
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask
  task automatic test_exhaustive();
    logic [1:0] tt [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      a8 = {7'b0, i[2]}; b8 = {7'b0, i[1]}; c = i[0]; in_valid = 1'b1;
      step();
      n_total++;
      if ({ov1, d1, e1} !== {1'b1, tt[i]})
        $display("FAIL truth abc=%03b: got ov,de=%b,%b%b want 1,%b", i[2:0], ov1, d1, e1, tt[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask
  task automatic test_latency();
    drain();
    a8 = 8'd1; b8 = 8'd1; c = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      in_valid = 1'b0;
      n_total++;
      if (k == 2 ? ({ov3, e3, d3} !== 3'b110) : (ov3 !== 1'b0))
        $display("FAIL latency k=%0d: got ov,e,d=%b,%b,%b want ov=%0d%s", k, ov3, e3, d3, k == 2, k == 2 ? " e=1 d=0" : "");
      else n_pass++;
    end
  endtask
  task automatic test_wide();
    a8 = 8'hFF; b8 = 8'h01; c = 1'b1; in_valid = 1'b1;
    step();
    n_total++;
    if ({ov8, e8, d8} !== {1'b1, 1'b1, 8'h01}) $display("FAIL wide_ff: got ov=%b e=%b d=%h want 1 1 01", ov8, e8, d8);
    else n_pass++;
    a8 = 8'h12; b8 = 8'h34; c = 1'b0;
    step();
    n_total++;
    if ({ov8, e8, d8} !== {1'b1, 1'b0, 8'h46}) $display("FAIL wide_12: got ov=%b e=%b d=%h want 1 0 46", ov8, e8, d8);
    else n_pass++;
    in_valid = 1'b0;
  endtask
  task automatic test_midreset();
    drain();
    for (int k = 0; k < 8; k++) begin
      a8 = 8'd1; b8 = 8'd1; c = 1'b1;
      in_valid = k < 3;
      rst = k == 1 || k == 2;
      step();
      n_total++;
      if (ov3 !== 1'b0 || ov83 !== 1'b0) $display("FAIL midrst k=%0d: got ov3=%b ov83=%b want 0", k, ov3, ov83);
      else n_pass++;
    end
    rst = 1'b0;
    a8 = 8'd1; b8 = 8'd0; c = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      in_valid = 1'b0;
      n_total++;
      if (k == 2 ? ({ov3, e3, d3} !== 3'b110) : (ov3 !== 1'b0))
        $display("FAIL postrst k=%0d: got ov,e,d=%b,%b,%b want ov=%0d", k, ov3, e3, d3, k == 2);
      else n_pass++;
    end
  endtask
  task automatic test_stream();
    logic [8:0] exp_sum [16];
    logic [7:0] sa [16], sb [16];
    logic       sc [16];
    drain();
    for (int i = 0; i < 16; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom); sc[i] = 1'($urandom);
      exp_sum[i] = 9'(sa[i]) + 9'(sb[i]) + 9'(sc[i]);
    end
    for (int k = 0; k < 20; k++) begin
      in_valid = k < 16;
      if (k < 16) begin a8 = sa[k]; b8 = sb[k]; c = sc[k]; end
      step();
      n_total++;
      if (k < 16 ? ({ov8, e8, d8} !== {1'b1, exp_sum[k]}) : (ov8 !== 1'b0))
        $display("FAIL stream_p1 k=%0d: got ov=%b sum=%h want ov=%0d sum=%h", k, ov8, {e8, d8}, k < 16, k < 16 ? exp_sum[k] : 9'h0);
      else n_pass++;
      n_total++;
      if (k >= 2 && k < 18 ? ({ov83, e83, d83} !== {1'b1, exp_sum[k-2]}) : (ov83 !== 1'b0))
        $display("FAIL stream_p3 k=%0d: got ov=%b sum=%h want ov=%0d", k, ov83, {e83, d83}, k >= 2 && k < 18);
      else n_pass++;
    end
  endtask
  initial begin
    test_reset();
    test_exhaustive();
    test_latency();
    test_wide();
    test_midreset();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
